sar_conversion_stage: RTL

- Successive-approximation conversion stage directly downstream of the PGA.
- Consumes the PGA's differential outputs, offset-binary around 0x8000, as vin_p/vin_n.
- Tracks the inputs for a fixed acquisition window, then freezes a held differential sample.
- Resolves a RESOLUTION-bit offset-binary code MSB-first, one bit per clock, against a modelled DAC/comparator.
- Raises a single-cycle data_valid pulse when the code is ready.

---
 rtl/sar_conversion_stage.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sar_conversion_stage.sv
// rtl/sar_conversion_stage.sv - successive-approximation conversion stage behind the PGA
//
// Purpose:
//   Tracks the differential PGA output for ACQ_CYCLES clocks and freezes the
//   last captured difference. It then resolves a RESOLUTION-bit offset-binary
//   code MSB-first, one bit per clock, against a modelled DAC/comparator.
//   When the code is ready, data_valid pulses for a single cycle.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous reset, active-high
//   enable     - stage enable; low aborts a conversion and parks the FSM in IDLE
//   start      - conversion request, sampled only in IDLE
//   vin_p      - positive input, unsigned, offset binary around 0x8000
//   vin_n      - negative input, unsigned, offset binary around 0x8000
//   busy       - high while in SAMPLE or CONVERT
//   data_valid - one-cycle pulse in DONE
//   data_out   - last conversion result, offset binary
//   overrange  - clamp flag of the last conversion

module sar_conversion_stage #(
  parameter int RESOLUTION = 12,
  parameter int ACQ_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic [15:0]           vin_p,
  input  logic [15:0]           vin_n,
  output logic                  busy,
  output logic                  data_valid,
  output logic [RESOLUTION-1:0] data_out,
  output logic                  overrange
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [7:0]            r_acq_cnt;
  logic signed [16:0]    r_hold;
  logic [4:0]            r_bit_idx;
  logic [RESOLUTION-1:0] r_trial;
  logic [RESOLUTION-1:0] r_data_out;
  logic                  r_overrange;

  logic signed [16:0]    w_diff;
  logic [17:0]           w_t_wide;
  logic                  w_t_neg;
  logic                  w_t_big;
  logic [15:0]           w_t;
  logic                  w_ovr;
  logic [RESOLUTION-1:0] w_test;
  logic [15:0]           w_dac;
  logic [RESOLUTION-1:0] w_trial_next;

  // Both operands are zero-extended to 17 bits, so the difference
  // (-65535..65535) always fits without overflow.
  assign w_diff = $signed({1'b0, vin_p} - {1'b0, vin_n});

  // The target is taken only from the held sample, so input movement after
  // the final SAMPLE edge cannot disturb the conversion.
  assign w_t_wide = {r_hold[16], r_hold} + 18'd32768;

  // t < 0 is the same condition as diff < -32768.
  // t > 65535 is the same condition as diff > 32767.
  // The clamp flag is therefore exactly the overrange condition.
  assign w_t_neg = w_t_wide[17];
  assign w_t_big = !w_t_wide[17] && w_t_wide[16];
  assign w_ovr   = w_t_neg || w_t_big;

  always_comb begin
    w_t = w_t_wide[15:0];
    if (w_t_neg) begin
      w_t = 16'h0000;
    end else if (w_t_big) begin
      w_t = 16'hFFFF;
    end
  end

  // Trial bit decision: keep the bit when the left-aligned DAC level does
  // not exceed the target.
  assign w_test       = r_trial | (RESOLUTION'(1) << r_bit_idx);
  assign w_dac        = 16'(w_test) << (16 - RESOLUTION);
  assign w_trial_next = (w_dac <= w_t) ? w_test : r_trial;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable && start) begin
          w_next_state = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (!enable) begin
          w_next_state = ST_IDLE;
        end else if (r_acq_cnt == 8'd0) begin
          w_next_state = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (!enable) begin
          w_next_state = ST_IDLE;
        end else if (r_bit_idx == 5'd0) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath. The result registers are loaded on the final CONVERT edge.
  // As a result, data_out is already updated in the same cycle that
  // data_valid is high. An aborted conversion never reaches that edge,
  // so the previous result is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acq_cnt   <= 8'd0;
      r_hold      <= 17'sd0;
      r_bit_idx   <= 5'd0;
      r_trial     <= '0;
      r_data_out  <= '0;
      r_overrange <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable && start) begin
            r_acq_cnt <= 8'(ACQ_CYCLES - 1);
          end
        end
        ST_SAMPLE: begin
          if (enable) begin
            r_hold    <= w_diff;
            r_acq_cnt <= r_acq_cnt - 8'd1;
            if (r_acq_cnt == 8'd0) begin
              r_bit_idx <= 5'(RESOLUTION - 1);
              r_trial   <= '0;
            end
          end
        end
        ST_CONVERT: begin
          if (enable) begin
            r_trial   <= w_trial_next;
            r_bit_idx <= r_bit_idx - 5'd1;
            if (r_bit_idx == 5'd0) begin
              r_data_out  <= w_trial_next;
              r_overrange <= w_ovr;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy       = (r_state == ST_SAMPLE) || (r_state == ST_CONVERT);
  assign data_valid = (r_state == ST_DONE);
  assign data_out   = r_data_out;
  assign overrange  = r_overrange;

endmodule
